// File: rtl/rc4_pkg.sv
// Types and constants shared by the RC4 loop controllers (key schedule, PRGA/decrypt).
package rc4_pkg;

  localparam int S_SIZE  = 256;
  localparam int IDX_W   = $clog2(S_SIZE);
  localparam int MEM_LAT = 2;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    WT_I,
    SV_I,
    RD_J,
    WT_J,
    SV_J,
    WR_I,
    WR_J,
    RD_F,
    WT_F,
    SV_F,
    WR_DEC,
    INC,
    DONE
  } prga_state_t;

  // Index arithmetic over the S array wraps modulo S_SIZE.
  function automatic logic [IDX_W-1:0] add_idx(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/prga_decrypt.sv
// RC4 PRGA walk over the permuted S RAM; XORs each keystream byte with the encrypted
// ROM byte and writes plaintext. All outputs are registered from the current state.
module prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN  = 32,
  parameter int READ_LAT = MEM_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  input  logic [7:0]  s_q,
  output logic        s_wren,
  output logic [9:0]  rom_address,
  input  logic [7:0]  rom_q,
  output logic [9:0]  dec_address,
  output logic [7:0]  dec_data,
  output logic        dec_wren
);

  // Wait states last READ_LAT cycles (READ_LAT must be at least 1).
  localparam logic [7:0] WAIT_INIT = 8'(READ_LAT - 1);

  prga_state_t      state_r;
  logic [IDX_W-1:0] i_r;
  logic [IDX_W-1:0] j_r;
  logic [9:0]       k_r;
  logic [7:0]       si_r;
  logic [7:0]       sj_r;
  logic [7:0]       f_r;
  logic [7:0]       enc_r;
  logic [7:0]       wait_r;

  logic             done_r;
  logic [7:0]       s_address_r;
  logic [7:0]       s_data_r;
  logic             s_wren_r;
  logic [9:0]       rom_address_r;
  logic [9:0]       dec_address_r;
  logic [7:0]       dec_data_r;
  logic             dec_wren_r;

  // Sequencer: one PRGA step per message byte, outputs registered from the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      i_r           <= '0;
      j_r           <= '0;
      k_r           <= 10'd0;
      si_r          <= 8'd0;
      sj_r          <= 8'd0;
      f_r           <= 8'd0;
      enc_r         <= 8'd0;
      wait_r        <= 8'd0;
      done_r        <= 1'b0;
      s_address_r   <= 8'd0;
      s_data_r      <= 8'd0;
      s_wren_r      <= 1'b0;
      rom_address_r <= 10'd0;
      dec_address_r <= 10'd0;
      dec_data_r    <= 8'd0;
      dec_wren_r    <= 1'b0;
    end else begin
      s_wren_r   <= 1'b0;
      dec_wren_r <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            i_r     <= '0;
            j_r     <= '0;
            k_r     <= 10'd0;
            state_r <= RD_I;
          end else begin
            state_r <= IDLE;
          end
        end
        RD_I: begin
          i_r           <= add_idx(i_r, 8'd1);
          s_address_r   <= add_idx(i_r, 8'd1);
          rom_address_r <= k_r;
          wait_r        <= WAIT_INIT;
          state_r       <= WT_I;
        end
        WT_I: begin
          if (wait_r == 8'd0) state_r <= SV_I;
          else                wait_r  <= wait_r - 8'd1;
        end
        SV_I: begin
          si_r    <= s_q;
          j_r     <= add_idx(j_r, s_q);
          state_r <= RD_J;
        end
        RD_J: begin
          s_address_r <= j_r;
          wait_r      <= WAIT_INIT;
          state_r     <= WT_J;
        end
        WT_J: begin
          if (wait_r == 8'd0) state_r <= SV_J;
          else                wait_r  <= wait_r - 8'd1;
        end
        SV_J: begin
          sj_r    <= s_q;
          state_r <= WR_I;
        end
        // When i == j the second write lands last with si, which is the correct RC4 result.
        WR_I: begin
          s_address_r <= i_r;
          s_data_r    <= sj_r;
          s_wren_r    <= 1'b1;
          state_r     <= WR_J;
        end
        WR_J: begin
          s_address_r <= j_r;
          s_data_r    <= si_r;
          s_wren_r    <= 1'b1;
          state_r     <= RD_F;
        end
        RD_F: begin
          s_address_r <= add_idx(si_r, sj_r);
          wait_r      <= WAIT_INIT;
          state_r     <= WT_F;
        end
        WT_F: begin
          if (wait_r == 8'd0) state_r <= SV_F;
          else                wait_r  <= wait_r - 8'd1;
        end
        SV_F: begin
          f_r     <= s_q;
          enc_r   <= rom_q;
          state_r <= WR_DEC;
        end
        WR_DEC: begin
          dec_address_r <= k_r;
          dec_data_r    <= f_r ^ enc_r;
          dec_wren_r    <= 1'b1;
          state_r       <= INC;
        end
        INC: begin
          k_r <= k_r + 10'd1;
          if ({22'd0, k_r} + 32'd1 < 32'(MSG_LEN)) state_r <= RD_I;
          else                                     state_r <= DONE;
        end
        DONE: begin
          done_r <= 1'b1;
          if (!start) state_r <= IDLE;
          else        state_r <= DONE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign done        = done_r;
  assign s_address   = s_address_r;
  assign s_data      = s_data_r;
  assign s_wren      = s_wren_r;
  assign rom_address = rom_address_r;
  assign dec_address = dec_address_r;
  assign dec_data    = dec_data_r;
  assign dec_wren    = dec_wren_r;

endmodule

// File: tb/tb_prga_decrypt.sv
// Scoreboard bench for prga_decrypt: three instances (MSG_LEN 2, 32, 300) on private
// S RAM / ROM models with two-cycle read latency, checked against a software RC4 PRGA.
module tb_prga_decrypt;
  import rc4_pkg::*;

  logic       clk = 1'b0;
  logic [2:0] reset;
  logic [2:0] start;
  logic [2:0] done;
  logic [2:0] s_wren;
  logic [2:0] dec_wren;
  logic [7:0] s_address [3];
  logic [7:0] s_data [3];
  logic [7:0] s_q [3];
  logic [9:0] rom_address [3];
  logic [7:0] rom_q [3];
  logic [9:0] dec_address [3];
  logic [7:0] dec_data [3];

  logic [7:0] s_mem [3][256];
  logic [7:0] s_pipe [3];
  logic [7:0] rom_mem [3][1024];
  logic [7:0] rom_pipe [3];

  logic       ld_en;
  int         ld_sel;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;

  logic [7:0]  img [256];
  logic [7:0]  model_s [256];
  logic [19:0] exp_q [$];
  logic [19:0] exp_v;

  int checks = 0;
  int errors = 0;
  int dec_cnt [3] = '{0, 0, 0};
  int swr_cnt [3] = '{0, 0, 0};
  int onehot_viol = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    prga_decrypt #(
      .MSG_LEN ((g == 0) ? 2 : ((g == 1) ? 32 : 300)),
      .READ_LAT(2)
    ) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .start      (start[g]),
      .done       (done[g]),
      .s_address  (s_address[g]),
      .s_data     (s_data[g]),
      .s_q        (s_q[g]),
      .s_wren     (s_wren[g]),
      .rom_address(rom_address[g]),
      .rom_q      (rom_q[g]),
      .dec_address(dec_address[g]),
      .dec_data   (dec_data[g]),
      .dec_wren   (dec_wren[g])
    );
  end

  // Memory models: write port plus a two-stage registered read path.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ld_en && ld_sel == g) s_mem[g][ld_addr] <= ld_data;
      else if (s_wren[g])       s_mem[g][s_address[g]] <= s_data[g];
      s_pipe[g]   <= s_mem[g][s_address[g]];
      s_q[g]      <= s_pipe[g];
      rom_pipe[g] <= rom_mem[g][rom_address[g]];
      rom_q[g]    <= rom_pipe[g];
    end
  end

  // Scoreboard side: pop and compare every plaintext write, count write-enable activity.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (s_wren[g] && dec_wren[g]) onehot_viol++;
      if (s_wren[g]) swr_cnt[g]++;
      if (dec_wren[g]) begin
        dec_cnt[g]++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL dec_unexpected inst=%0d addr=%0d data=%02h (no write expected)",
                   g, dec_address[g], dec_data[g]);
        end else begin
          exp_v = exp_q.pop_front();
          if ({2'(g), dec_address[g], dec_data[g]} !== exp_v) begin
            errors++;
            $display("FAIL dec_write inst=%0d got addr=%0d data=%02h, want inst=%0d addr=%0d data=%02h",
                     g, dec_address[g], dec_data[g], exp_v[19:18], exp_v[17:8], exp_v[7:0]);
          end
        end
      end
    end
  end

  task automatic load_s(input int g);
    for (int x = 0; x < 256; x++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_sel = g; ld_addr = 8'(x); ld_data = img[x];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic fill_identity;
    for (int x = 0; x < 256; x++) img[x] = 8'(x);
  endtask

  task automatic copy_model(input int g);
    for (int x = 0; x < 256; x++) model_s[x] = s_mem[g][x];
  endtask

  // Software RC4 PRGA from i=j=0 over model_s; pushes the expected plaintext writes.
  task automatic model_push(input int g, input int n);
    logic [7:0] mi, mj, t, f;
    mi = 8'd0; mj = 8'd0;
    for (int k = 0; k < n; k++) begin
      mi = mi + 8'd1;
      mj = mj + model_s[mi];
      t = model_s[mi]; model_s[mi] = model_s[mj]; model_s[mj] = t;
      f = model_s[8'(model_s[mi] + model_s[mj])];
      exp_q.push_back({2'(g), 10'(k), f ^ rom_mem[g][k]});
    end
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk); start[g] = 1'b1;
    @(posedge clk); #1; start[g] = 1'b0;
  endtask

  // Counts edges after the start-sampling edge until done is seen (bounded).
  task automatic wait_done(input int g, input int budget, output int edges);
    edges = 0;
    while (done[g] !== 1'b1 && edges < budget) begin
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic test_reset;
    reset = 3'b111; start = 3'b000; ld_en = 1'b0; ld_sel = 0; ld_addr = 8'd0; ld_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({done[g], s_address[g], s_data[g], s_wren[g], rom_address[g],
           dec_address[g], dec_data[g], dec_wren[g]} !== 48'd0) begin
        errors++;
        $display("FAIL reset_outputs inst=%0d got nonzero outputs, want all 0", g);
      end
    end
    @(negedge clk); reset = 3'b000;
  endtask

  task automatic test_two_byte;
    int e, d0, w0;
    fill_identity(); load_s(0);
    rom_mem[0][0] = 8'h41; rom_mem[0][1] = 8'h00;
    exp_q.push_back({2'd0, 10'd0, 8'h43});
    exp_q.push_back({2'd0, 10'd1, 8'h05});
    d0 = dec_cnt[0]; w0 = swr_cnt[0];
    pulse_start(0);
    wait_done(0, 100, e);
    checks++; if (e !== 33) begin errors++; $display("FAIL two_byte_done_edge got %0d want 33", e); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL two_byte_pending got %0d want 0", exp_q.size()); end
    checks++; if (s_mem[0][2] !== 8'd3 || s_mem[0][3] !== 8'd2) begin
      errors++; $display("FAIL two_byte_swap got s2=%0d s3=%0d want 3 2", s_mem[0][2], s_mem[0][3]);
    end
    checks++; if (dec_cnt[0] - d0 !== 2) begin errors++; $display("FAIL two_byte_dec_count got %0d want 2", dec_cnt[0] - d0); end
    checks++; if (swr_cnt[0] - w0 !== 4) begin errors++; $display("FAIL two_byte_s_writes got %0d want 4", swr_cnt[0] - w0); end
  endtask

  task automatic test_keystream32;
    int e, d0;
    fill_identity(); load_s(1);
    for (int k = 0; k < 1024; k++) rom_mem[1][k] = 8'h00;
    for (int x = 0; x < 256; x++) model_s[x] = img[x];
    model_push(1, 32);
    d0 = dec_cnt[1];
    pulse_start(1);
    wait_done(1, 700, e);
    checks++; if (e !== 513) begin errors++; $display("FAIL ks32_done_edge got %0d want 513", e); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL ks32_pending got %0d want 0", exp_q.size()); end
    checks++; if (dec_cnt[1] - d0 !== 32) begin errors++; $display("FAIL ks32_dec_count got %0d want 32", dec_cnt[1] - d0); end
  endtask

  task automatic test_wrap300;
    int e, d0, w0, v0, r;
    logic [7:0] t;
    fill_identity();
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0); t = img[x]; img[x] = img[r]; img[r] = t;
    end
    load_s(2);
    for (int k = 0; k < 1024; k++) rom_mem[2][k] = 8'($urandom_range(255, 0));
    for (int x = 0; x < 256; x++) model_s[x] = img[x];
    model_push(2, 300);
    d0 = dec_cnt[2]; w0 = swr_cnt[2]; v0 = onehot_viol;
    pulse_start(2);
    wait_done(2, 6000, e);
    checks++; if (e !== 4801) begin errors++; $display("FAIL wrap_done_edge got %0d want 4801", e); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL wrap_pending got %0d want 0", exp_q.size()); end
    checks++; if (dec_cnt[2] - d0 !== 300) begin errors++; $display("FAIL wrap_dec_count got %0d want 300", dec_cnt[2] - d0); end
    checks++; if (swr_cnt[2] - w0 !== 600) begin errors++; $display("FAIL wrap_s_writes got %0d want 600", swr_cnt[2] - w0); end
    checks++; if (onehot_viol - v0 !== 0) begin errors++; $display("FAIL wren_onehot got %0d overlaps want 0", onehot_viol - v0); end
  endtask

  task automatic test_mid_run_reset;
    int e, d0;
    copy_model(1); model_push(1, 32);
    d0 = dec_cnt[1];
    pulse_start(1);
    repeat (199) @(posedge clk);
    @(negedge clk); reset[1] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({done[1], s_address[1], s_data[1], s_wren[1], rom_address[1],
         dec_address[1], dec_data[1], dec_wren[1]} !== 48'd0) begin
      errors++; $display("FAIL midreset_outputs got nonzero outputs, want all 0");
    end
    checks++; if (g_dut[1].u_dut.state_r !== IDLE) begin
      errors++; $display("FAIL midreset_state got %0d want IDLE", g_dut[1].u_dut.state_r);
    end
    checks++; if (dec_cnt[1] - d0 !== 12) begin errors++; $display("FAIL midreset_written got %0d want 12", dec_cnt[1] - d0); end
    @(negedge clk); reset[1] = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    copy_model(1); model_push(1, 32);
    d0 = dec_cnt[1];
    pulse_start(1);
    wait_done(1, 700, e);
    checks++; if (e !== 513) begin errors++; $display("FAIL rerun_done_edge got %0d want 513", e); end
    checks++; if (exp_q.size() !== 0 || dec_cnt[1] - d0 !== 32) begin
      errors++; $display("FAIL rerun_bytes got pending=%0d written=%0d want 0 32", exp_q.size(), dec_cnt[1] - d0);
    end
  endtask

  task automatic test_start_held;
    int e, d0;
    copy_model(1); model_push(1, 32);
    d0 = dec_cnt[1];
    @(negedge clk); start[1] = 1'b1;
    @(posedge clk); #1;
    e = 0;
    while (done[1] !== 1'b1 && e < 700) begin
      @(posedge clk); #1; e++;
      if (e == 100) start[1] = 1'b0;
      if (e == 103) start[1] = 1'b1;
    end
    checks++; if (e !== 513) begin errors++; $display("FAIL held_done_edge got %0d want 513", e); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (done[1] !== 1'b1) begin errors++; $display("FAIL held_done_stays got %b want 1", done[1]); end
    start[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done[1] !== 1'b0 || g_dut[1].u_dut.state_r !== IDLE) begin
      errors++; $display("FAIL held_release got done=%b state=%0d want 0 IDLE", done[1], g_dut[1].u_dut.state_r);
    end
    checks++; if (exp_q.size() !== 0 || dec_cnt[1] - d0 !== 32) begin
      errors++; $display("FAIL held_bytes got pending=%0d written=%0d want 0 32", exp_q.size(), dec_cnt[1] - d0);
    end
    model_push(1, 32);
    d0 = dec_cnt[1];
    pulse_start(1);
    wait_done(1, 700, e);
    checks++; if (e !== 513) begin errors++; $display("FAIL second_done_edge got %0d want 513", e); end
    checks++; if (exp_q.size() !== 0 || dec_cnt[1] - d0 !== 32) begin
      errors++; $display("FAIL second_bytes got pending=%0d written=%0d want 0 32", exp_q.size(), dec_cnt[1] - d0);
    end
  endtask

  initial begin
    test_reset();
    test_two_byte();
    test_keystream32();
    test_wrap300();
    test_mid_run_reset();
    test_start_held();
    checks++; if (onehot_viol !== 0) begin errors++; $display("FAIL wren_onehot_total got %0d want 0", onehot_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
